// File: rtl/inout_chan_merger_pkg.sv
// inout_chan_merger_pkg: shared constants, beat/header types and arbitration modes for the channel merger
// Ports: none (package only)
package inout_chan_merger_pkg;
   localparam int MERGE_NUM_CH = 4;
   localparam int MERGE_DATA_W = 8;
   localparam int MERGE_DEPTH  = 4;
   localparam int MERGE_CH_W   = MERGE_NUM_CH > 2 ? $clog2(MERGE_NUM_CH) : 1;
   typedef logic [MERGE_CH_W-1:0] chanIdxT;
   typedef logic [MERGE_DATA_W-1:0] payloadT;
   typedef struct packed {
      chanIdxT chan;
   } mergeHdrSt;
   typedef struct packed {
      mergeHdrSt hdr;
      payloadT   data;
   } mergeBeatSt;
   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arbModeT;
endpackage

// File: rtl/inout_chan_fifo.sv
// inout_chan_fifo: per-channel payload FIFO with wrap-bit pointers
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata read side (rdata = head, valid when !empty);
//        empty, full, level = current occupancy
module inout_chan_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              empty,
   output logic              full,
   output logic [LW-1:0]     level
);
   logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   assign empty = wr_q == rd_q;
   assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign level = wr_q - rd_q;
   assign rdata = mem_q[rd_q[AW-1:0]];
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + LW'(push);
      rd_d = rd_q + LW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
      mem_q <= mem_d;
   end
endmodule

// File: rtl/inout_chan_merger.sv
// inout_chan_merger: N-to-1 merger of buffered valid/ready channels into one header+payload stream
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data per channel (channel i at [i*DATA_W +: DATA_W]);
//        out_valid/out_ready/out_hdr (source channel)/out_data output stream; fill_lvl per-channel FIFO occupancy;
//        pkt_count delivered beats, wrapping
module inout_chan_merger
   import inout_chan_merger_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 4,
   parameter int PRIO_MODE = 0,
   parameter int CNT_W     = 16,
   localparam int CH_W     = NUM_CH > 2 ? $clog2(NUM_CH) : 1,
   localparam int LW       = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_hdr,
   output logic [DATA_W-1:0]        out_data,
   output logic [NUM_CH*LW-1:0]     fill_lvl,
   output logic [CNT_W-1:0]         pkt_count
);
   localparam arbModeT ARB = PRIO_MODE != 0 ? ARB_FIXED : ARB_RR;
   logic [NUM_CH-1:0] empty, full, pop;
   logic [NUM_CH*DATA_W-1:0] head;
   logic load_en, gnt_found, take;
   logic [CH_W-1:0] gnt_idx, cand;
   logic out_valid_q, out_valid_d;
   logic [CH_W-1:0] out_hdr_q, out_hdr_d, last_grant_q, last_grant_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
   // Ready depends only on registered occupancy, and is held low during reset so nothing is accepted then.
   assign in_ready = rst ? '0 : ~full;
   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_fifo
         inout_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[g] && in_ready[g]),
            .pop   (pop[g]),
            .wdata (in_data[g*DATA_W +: DATA_W]),
            .rdata (head[g*DATA_W +: DATA_W]),
            .empty (empty[g]),
            .full  (full[g]),
            .level (fill_lvl[g*LW +: LW])
         );
      end
   endgenerate
   always_comb begin
      load_en   = !out_valid_q || out_ready;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      // Round-robin scans from the channel after the last grant; fixed mode scans from channel 0.
      for (int k = 0; k < NUM_CH; k++) begin
         cand = CH_W'(ARB == ARB_FIXED ? k : (int'(last_grant_q) + 1 + k) % NUM_CH);
         if (!gnt_found && !empty[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
      take         = load_en && gnt_found;
      pop          = take ? NUM_CH'(1) << gnt_idx : '0;
      out_valid_d  = load_en ? gnt_found : out_valid_q;
      out_hdr_d    = take ? gnt_idx : out_hdr_q;
      out_data_d   = take ? head[gnt_idx*DATA_W +: DATA_W] : out_data_q;
      last_grant_d = (take && ARB == ARB_RR) ? gnt_idx : last_grant_q;
      pkt_count_d  = pkt_count_q + CNT_W'(out_valid_q && out_ready);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_hdr_q    <= '0;
         out_data_q   <= '0;
         last_grant_q <= CH_W'(NUM_CH - 1);
         pkt_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_hdr_q    <= out_hdr_d;
         out_data_q   <= out_data_d;
         last_grant_q <= last_grant_d;
         pkt_count_q  <= pkt_count_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_hdr   = out_hdr_q;
   assign out_data  = out_data_q;
   assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_inout_chan_merger.sv
// tb_inout_chan_merger: scoreboard bench for a round-robin (16-bit count) and a fixed-priority (4-bit count) merger
module tb_inout_chan_merger;
   localparam int N = 4, W = 8, D = 4, LW = 3;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [N-1:0] in_valid [2];
   logic [N-1:0] in_ready [2];
   logic [N*W-1:0] in_data [2];
   logic out_ready [2];
   logic out_valid [2];
   logic [1:0] out_hdr [2];
   logic [W-1:0] out_data [2];
   logic [N*LW-1:0] fill_lvl [2];
   logic [15:0] pkt0;
   logic [3:0] pkt1;
   inout_chan_merger #(.NUM_CH(N), .DATA_W(W), .DEPTH(D), .PRIO_MODE(0), .CNT_W(16)) dut_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_hdr(out_hdr[0]), .out_data(out_data[0]),
      .fill_lvl(fill_lvl[0]), .pkt_count(pkt0));
   inout_chan_merger #(.NUM_CH(N), .DATA_W(W), .DEPTH(D), .PRIO_MODE(1), .CNT_W(4)) dut_fx (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_hdr(out_hdr[1]), .out_data(out_data[1]),
      .fill_lvl(fill_lvl[1]), .pkt_count(pkt1));
   int n_chk = 0, n_fail = 0;
   bit started = 1'b0, gate_all = 1'b1;
   int rdy_mode [2] = '{1, 1};
   logic [W-1:0] pend [2][N][$];
   logic [W-1:0] mq [2][N][$];
   logic [W+1:0] sb [2][$];
   bit m_v [2];
   int m_last [2];
   int m_cnt [2];
   logic [N-1:0] m_acc [2];
   logic [N-1:0] er;
   logic [N*LW-1:0] ef;
   function automatic void chk(string nm, int d, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d got=0x%0h want=0x%0h", nm, d, act, exp);
      end
   endfunction
   // Reference: per-channel queues of accepted beats, a one-beat output slot and a pointer for round-robin.
   function automatic void model_step(int d);
      int w;
      logic [W-1:0] v;
      if (rst) begin
         for (int c = 0; c < N; c++) mq[d][c].delete();
         sb[d].delete();
         m_v[d] = 0;
         m_last[d] = N - 1;
         m_cnt[d] = 0;
         m_acc[d] = '0;
         return;
      end
      for (int c = 0; c < N; c++) m_acc[d][c] = in_valid[d][c] && mq[d][c].size() < D;
      if (m_v[d] && out_ready[d]) m_cnt[d] = (m_cnt[d] + 1) % (d == 0 ? 65536 : 16);
      if (!m_v[d] || out_ready[d]) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            int c = d == 1 ? k : (m_last[d] + 1 + k) % N;
            if (w < 0 && mq[d][c].size() != 0) w = c;
         end
         m_v[d] = w >= 0;
         if (w >= 0) begin
            v = mq[d][w].pop_front();
            sb[d].push_back({2'(w), v});
            if (d == 0) m_last[d] = w;
         end
      end
      for (int c = 0; c < N; c++) if (m_acc[d][c]) mq[d][c].push_back(in_data[d][c*W +: W]);
   endfunction
   function automatic bit busy();
      for (int d = 0; d < 2; d++) begin
         if (sb[d].size() != 0 || m_v[d]) return 1'b1;
         for (int c = 0; c < N; c++) if (pend[d][c].size() != 0 || mq[d][c].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction
   initial begin : driver
      forever begin
         @(posedge clk);
         if (rst) started = 1'b1;
         for (int d = 0; d < 2; d++) begin
            model_step(d);
            for (int c = 0; c < N; c++) if (m_acc[d][c]) void'(pend[d][c].pop_front());
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
               in_valid[d][c] = pend[d][c].size() != 0 && (gate_all || $urandom_range(3) != 0);
               if (pend[d][c].size() != 0) in_data[d][c*W +: W] = pend[d][c][0];
               else in_data[d][c*W +: W] = W'($urandom);
            end
            out_ready[d] = rdy_mode[d] == 2 ? 1'($urandom_range(1)) : rdy_mode[d] == 1;
         end
      end
   end
   always @(negedge clk) begin : monitor
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
               er[c] = !rst && mq[d][c].size() < D;
               ef[c*LW +: LW] = LW'(mq[d][c].size());
            end
            chk("in_ready", d, int'(in_ready[d]), int'(er));
            chk("fill_lvl", d, int'(fill_lvl[d]), int'(ef));
            chk("out_valid", d, int'(out_valid[d]), int'(m_v[d]));
            chk("pkt_count", d, d == 0 ? int'(pkt0) : int'(pkt1), m_cnt[d]);
            if (out_valid[d]) begin
               chk("beat_expected", d, int'(sb[d].size() != 0), 1);
               if (sb[d].size() != 0) begin
                  chk("beat", d, int'({out_hdr[d], out_data[d]}), int'(sb[d][0]));
                  if (out_ready[d]) void'(sb[d].pop_front());
               end
            end
         end
      end
   end
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic drain();
      for (int i = 0; i < 400 && busy(); i++) cyc(1);
      chk("drain", 0, int'(busy()), 0);
   endtask
   initial begin : main
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = '0;
         in_data[d] = '0;
         out_ready[d] = 1'b0;
      end
      cyc(3);
      for (int d = 0; d < 2; d++) chk("rst_in_ready", d, int'(in_ready[d]), 0);
      rst = 1'b0;
      cyc(1);
      for (int d = 0; d < 2; d++) begin
         chk("post_rst_in_ready", d, int'(in_ready[d]), 'hF);
         chk("post_rst_valid", d, int'(out_valid[d]), 0);
      end
      pend[0][2].push_back(8'hA5);
      for (int i = 0; i < 10 && pend[0][2].size() != 0; i++) cyc(1);
      chk("lat_n1_valid", 0, int'(out_valid[0]), 0);
      cyc(1);
      chk("lat_n2_valid", 0, int'(out_valid[0]), 1);
      chk("lat_n2_hdr", 0, int'(out_hdr[0]), 2);
      chk("lat_n2_data", 0, int'(out_data[0]), 'hA5);
      cyc(1);
      chk("lat_n3_valid", 0, int'(out_valid[0]), 0);
      for (int c = 0; c < N; c++) begin
         pend[0][c].push_back(8'h10 + 8'(c));
         pend[0][c].push_back(8'h20 + 8'(c));
      end
      drain();
      chk("pkt_after_rr", 0, int'(pkt0), 9);
      rdy_mode[0] = 0;
      for (int v = 1; v <= 6; v++) pend[0][1].push_back(8'(v));
      cyc(10);
      chk("bp_fill_ch1", 0, int'(fill_lvl[0][LW +: LW]), 4);
      chk("bp_in_ready_ch1", 0, int'(in_ready[0][1]), 0);
      chk("bp_hold_valid", 0, int'(out_valid[0]), 1);
      chk("bp_hold_data", 0, int'(out_data[0]), 1);
      rdy_mode[0] = 1;
      drain();
      chk("pkt_after_bp", 0, int'(pkt0), 15);
      for (int i = 0; i < 12; i++) pend[1][0].push_back(8'h40 + 8'(i));
      for (int i = 0; i < 6; i++) pend[1][3].push_back(8'h80 + 8'(i));
      cyc(8);
      chk("fx_fill_ch3", 1, int'(fill_lvl[1][3*LW +: LW]), 4);
      chk("fx_hdr", 1, int'(out_hdr[1]), 0);
      drain();
      rdy_mode = '{0, 0};
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 3; i++) pend[d][0].push_back(8'h60 + 8'(i));
         for (int i = 0; i < 2; i++) pend[d][1].push_back(8'h70 + 8'(i));
      end
      cyc(6);
      rst = 1'b1;
      for (int d = 0; d < 2; d++) for (int c = 0; c < N; c++) pend[d][c].delete();
      cyc(1);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_valid", d, int'(out_valid[d]), 0);
         chk("midrst_fill", d, int'(fill_lvl[d]), 0);
         chk("midrst_pkt", d, d == 0 ? int'(pkt0) : int'(pkt1), 0);
      end
      rdy_mode = '{1, 1};
      cyc(5);
      gate_all = 1'b0;
      rdy_mode = '{2, 2};
      for (int i = 0; i < 1500; i++) begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++)
               if (pend[d][c].size() < 3 && $urandom_range(3) == 0) pend[d][c].push_back(W'($urandom));
         cyc(1);
      end
      gate_all = 1'b1;
      rdy_mode = '{1, 1};
      drain();
      cyc(3);
      for (int d = 0; d < 2; d++) chk("final_sb", d, int'(sb[d].size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
